// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry front end and parking_system.
// FSM encoding, default timing constants and the pass digit width.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        HOLD    = 2'd3
    } entry_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int ENTRY_TIMEOUT_DEF   = 1000;
    localparam int PASS_W              = 2;

endpackage

// File: rtl/debounce_sync.sv
// One-bit debouncer with an optional two-flop input synchronizer.
// PARKING_FE_SYNC_EN adds the synchronizer (two extra cycles of latency).
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    logic       in_s;
    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;

`ifdef PARKING_FE_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer ahead of the stability counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], raw_i};
    end

    assign in_s = sync_q[1];
`else
    assign in_s = raw_i;
`endif

    // Count consecutive samples that disagree with the output; flip when enough
    always_comb begin
        cnt_d   = 8'd0;
        level_d = level_q;
        if (in_s != level_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                level_d = in_s;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/parking_entry_frontend.sv
// Debounces the gate sensors and keypad and runs the two-digit entry.
// PARKING_FE_SYNC_EN adds input synchronizers (latency DEBOUNCE_CYCLES+2).
module parking_entry_frontend
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ENTRY_TIMEOUT   = ENTRY_TIMEOUT_DEF,
    parameter int TO_W            = 20
) (
    input  logic              clock_in,
    input  logic              rst_in,
    input  logic              raw_front,
    input  logic              raw_back,
    input  logic              key_pressed,
    input  logic [PASS_W-1:0] key_code,
    output logic              Front_Sensor,
    output logic              Back_Sensor,
    output logic [PASS_W-1:0] pass_1,
    output logic [PASS_W-1:0] pass_2,
    output logic              entry_busy,
    output logic              entry_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TIMEOUT - 1);

    logic              front_db, back_db, key_db;
    logic              front_prev_q, back_prev_q, key_prev_q;
    logic              rise_front, rise_back, rise_key;
    logic [PASS_W-1:0] code;

    entry_state_e      state_q;
    logic [PASS_W-1:0] pass1_q, pass2_q;
    logic [TO_W-1:0]   to_q;
    logic              to_pulse_q;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_front (
        .clk_i   (clock_in),
        .rst_ni  (rst_in),
        .raw_i   (raw_front),
        .level_o (front_db)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clk_i   (clock_in),
        .rst_ni  (rst_in),
        .raw_i   (raw_back),
        .level_o (back_db)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_key (
        .clk_i   (clock_in),
        .rst_ni  (rst_in),
        .raw_i   (key_pressed),
        .level_o (key_db)
    );

`ifdef PARKING_FE_SYNC_EN
    logic [PASS_W-1:0] code_s1_q, code_s2_q;

    // Key code rides the same two-flop depth as key_pressed
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            code_s1_q <= '0;
            code_s2_q <= '0;
        end else begin
            code_s1_q <= key_code;
            code_s2_q <= code_s1_q;
        end
    end

    assign code = code_s2_q;
`else
    assign code = key_code;
`endif

    // Previous debounced levels for rising-edge detection
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            front_prev_q <= 1'b0;
            back_prev_q  <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            front_prev_q <= front_db;
            back_prev_q  <= back_db;
            key_prev_q   <= key_db;
        end
    end

    assign rise_front = front_db & ~front_prev_q;
    assign rise_back  = back_db  & ~back_prev_q;
    assign rise_key   = key_db   & ~key_prev_q;

    // Entry FSM: key capture beats timeout, timeout beats front drop
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            pass1_q    <= '0;
            pass2_q    <= '0;
            to_q       <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    to_q <= '0;
                    if (rise_front) begin
                        state_q <= WAIT_D1;
                        pass1_q <= '0;
                        pass2_q <= '0;
                    end
                end
                WAIT_D1, WAIT_D2: begin
                    if (rise_key) begin
                        to_q <= '0;
                        if (state_q == WAIT_D1) begin
                            pass1_q <= code;
                            state_q <= WAIT_D2;
                        end else begin
                            pass2_q <= code;
                            state_q <= HOLD;
                        end
                    end else if (to_q == TO_LAST) begin
                        state_q    <= IDLE;
                        to_pulse_q <= 1'b1;
                        pass1_q    <= '0;
                        pass2_q    <= '0;
                        to_q       <= '0;
                    end else if (!front_db) begin
                        state_q <= IDLE;
                        pass1_q <= '0;
                        pass2_q <= '0;
                        to_q    <= '0;
                    end else if (to_q != {TO_W{1'b1}}) begin
                        to_q <= to_q + 1'b1;
                    end
                end
                HOLD: begin
                    to_q <= '0;
                    if (rise_back) begin
                        state_q <= IDLE;
                        pass1_q <= '0;
                        pass2_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Front_Sensor  = front_db;
    assign Back_Sensor   = back_db;
    assign pass_1        = pass1_q;
    assign pass_2        = pass2_q;
    assign entry_busy    = (state_q == WAIT_D1) || (state_q == WAIT_D2);
    assign entry_timeout = to_pulse_q;

endmodule

// File: tb/tb_parking_entry_frontend.sv
// Directed bench for parking_entry_frontend with a behavioural model.
// Honours PARKING_FE_SYNC_EN (two extra cycles of input latency).
module tb_parking_entry_frontend;

    localparam int DB = 4;
    localparam int T  = 20;
`ifdef PARKING_FE_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rf    = 1'b0;
    logic       rb    = 1'b0;
    logic       kp    = 1'b0;
    logic [1:0] kc    = 2'd0;

    logic       front_o, back_o, busy_o, to_o;
    logic [1:0] p1_o, p2_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parking_entry_frontend #(
        .DEBOUNCE_CYCLES(DB),
        .ENTRY_TIMEOUT  (T),
        .TO_W           (20)
    ) dut (
        .clock_in     (clk),
        .rst_in       (rst_n),
        .raw_front    (rf),
        .raw_back     (rb),
        .key_pressed  (kp),
        .key_code     (kc),
        .Front_Sensor (front_o),
        .Back_Sensor  (back_o),
        .pass_1       (p1_o),
        .pass_2       (p2_o),
        .entry_busy   (busy_o),
        .entry_timeout(to_o)
    );

    // ---------------- behavioural model ----------------
    // Sensor outputs follow a raw level once it has been seen on DB
    // consecutive samples; entry progress is tracked as "digits collected".
    int         m_mode;
    int         m_wait;
    logic [1:0] m_p1, m_p2;
    bit         m_to;
    bit         m_lvl [0:2];
    bit         m_prev[0:2];
    bit         hh    [0:2][0:DB-1];
    int         hn    [0:2];
    logic [4:0] sy1, sy2, raw, din;
    bit         rise  [0:2];
    int         diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_wait = 0; m_p1 = 0; m_p2 = 0; m_to = 0;
            sy1 = 0; sy2 = 0;
            for (int i = 0; i < 3; i++) begin
                m_lvl[i] = 0; m_prev[i] = 0; hn[i] = 0;
            end
        end else begin
            raw = {kc, kp, rb, rf};
            din = (SD == 2) ? sy2 : raw;
            for (int i = 0; i < 3; i++) rise[i] = m_lvl[i] && !m_prev[i];
            m_to = 0;
            if (m_mode == 0) begin
                if (rise[0]) begin
                    m_mode = 1; m_wait = 0; m_p1 = 0; m_p2 = 0;
                end
            end else if (m_mode == 3) begin
                if (rise[1]) begin
                    m_mode = 0; m_p1 = 0; m_p2 = 0;
                end
            end else begin
                if (rise[2]) begin
                    if (m_mode == 1) m_p1 = din[4:3];
                    else             m_p2 = din[4:3];
                    m_mode = m_mode + 1;
                    m_wait = 0;
                end else if (m_wait == T - 1) begin
                    m_mode = 0; m_to = 1; m_p1 = 0; m_p2 = 0;
                end else if (!m_lvl[0]) begin
                    m_mode = 0; m_p1 = 0; m_p2 = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
            for (int i = 0; i < 3; i++) m_prev[i] = m_lvl[i];
            for (int i = 0; i < 3; i++) begin
                for (int j = DB - 1; j > 0; j--) hh[i][j] = hh[i][j-1];
                hh[i][0] = din[i];
                if (hn[i] < DB) hn[i] = hn[i] + 1;
                diff = 0;
                for (int j = 0; j < hn[i]; j++)
                    if (hh[i][j] != m_lvl[i]) diff = diff + 1;
                if (diff == DB) m_lvl[i] = !m_lvl[i];
            end
            sy2 = sy1;
            sy1 = raw;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [7:0] got, exp;
        got = {front_o, back_o, p1_o, p2_o, busy_o, to_o};
        exp = {m_lvl[0], m_lvl[1], m_p1, m_p2,
               (m_mode == 1 || m_mode == 2), m_to};
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, got, exp);
        end
    end

    // ---------------- directed stimulus ----------------
    int pcnt;
    int cyc;
    int pulse_at;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            if (to_o === 1'b1) begin
                pcnt     = pcnt + 1;
                pulse_at = cyc;
            end
        end
    endtask

    function automatic logic [7:0] outs();
        return {front_o, back_o, p1_o, p2_o, busy_o, to_o};
    endfunction

    initial begin
        pcnt = 0; cyc = 0; pulse_at = -1;
        #50;
        chk("reset_hold_outputs", outs(), 8'h00);
        #50;
        rst_n = 1'b1;
        step(2);
        chk("after_reset_outputs", outs(), 8'h00);

        // short glitch must not propagate
        rf = 1'b1;
        step(DB - 1);
        rf = 1'b0;
        step(8);
        chk("glitch_front", front_o, 1'b0);

        // held level appears exactly DB(+SD) edges after first sample
        rf = 1'b1;
        step(DB + SD - 1);
        chk("front_before_latency", front_o, 1'b0);
        step(1);
        chk("front_at_latency", front_o, 1'b1);
        step(1);
        chk("busy_after_front", busy_o, 1'b1);

        // two digits: 1 then 2
        step(2);
        kc = 2'd1; kp = 1'b1;
        step(6);
        kp = 1'b0;
        step(6);
        kc = 2'd2; kp = 1'b1;
        step(6);
        kp = 1'b0;
        step(DB + SD + 2);
        kc = 2'd0;
        chk("pass1_captured", p1_o, 2'd1);
        chk("pass2_captured", p2_o, 2'd2);
        chk("busy_in_hold", busy_o, 1'b0);

        // car passes: digits clear the edge after Back_Sensor rises
        rb = 1'b1;
        step(DB + SD);
        chk("back_rise", back_o, 1'b1);
        chk("pass1_kept_on_back_rise", p1_o, 2'd1);
        step(1);
        chk("pass_cleared_by_back", {p1_o, p2_o}, 4'h0);
        step(5);
        rb = 1'b0;

        // timeout: front up, no key
        rf = 1'b0;
        step(DB + SD + 2);
        pcnt = 0; cyc = 0; pulse_at = -1;
        rf = 1'b1;
        step(T + DB + SD + 6);
        chk("timeout_pulse_count", pcnt, 1);
        chk("timeout_pulse_cycle", pulse_at, DB + SD + 1 + T);
        chk("timeout_idle", {busy_o, p1_o, p2_o}, 5'h00);

        // key rise on the exact timeout cycle wins
        rf = 1'b0;
        step(DB + SD + 2);
        pcnt = 0;
        rf = 1'b1;
        step(T);
        kc = 2'd3; kp = 1'b1;
        step(8);
        kp = 1'b0;
        chk("exact_to_no_pulse", pcnt, 0);
        chk("exact_to_captured", p1_o, 2'd3);
        chk("exact_to_in_d2", busy_o, 1'b1);

        // front dropped in WAIT_D2: abort without pulse
        rf = 1'b0;
        kc = 2'd0;
        step(10);
        chk("drop_busy", busy_o, 1'b0);
        chk("drop_cleared", p1_o, 2'd0);
        chk("drop_no_pulse", pcnt, 0);
        rf = 1'b1;
        step(DB + SD + 2);
        chk("reentry_busy", busy_o, 1'b1);
        chk("reentry_pass1", p1_o, 2'd0);

        // reach HOLD, front drop does not clear
        kc = 2'd1; kp = 1'b1;
        step(8);
        kp = 1'b0;
        step(6);
        kc = 2'd2; kp = 1'b1;
        step(8);
        kp = 1'b0;
        step(2);
        chk("hold_pass", {busy_o, p1_o, p2_o}, 5'b0_01_10);
        rf = 1'b0;
        step(DB + SD + 3);
        chk("hold_front_drop_keeps", {front_o, p1_o, p2_o}, 5'b0_01_10);

        // asynchronous reset in HOLD
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 8'h00);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("post_reset_idle", outs(), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
